// File: rtl/uncached_data_axi.sv
// rtl/uncached_data_axi.sv - uncached data-side AXI master with posted write buffer
module uncached_data_axi #(
   parameter logic [3:0] ID    = 4'd1,
   parameter int         DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,

   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [3:0]  mem_wsel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_rvalid,
   output logic        mem_wack,
   output logic        wbuf_empty,

   output logic [3:0]  d_arid,
   output logic [31:0] d_araddr,
   output logic [3:0]  d_arlen,
   output logic [2:0]  d_arsize,
   output logic [1:0]  d_arburst,
   output logic [1:0]  d_arlock,
   output logic [3:0]  d_arcache,
   output logic [2:0]  d_arprot,
   output logic        d_arvalid,
   input  logic        d_arready,

   input  logic [3:0]  d_rid,
   input  logic [31:0] d_rdata,
   input  logic [1:0]  d_rresp,
   input  logic        d_rlast,
   input  logic        d_rvalid,
   output logic        d_rready,

   output logic [3:0]  d_awid,
   output logic [31:0] d_awaddr,
   output logic [3:0]  d_awlen,
   output logic [2:0]  d_awsize,
   output logic [1:0]  d_awburst,
   output logic [1:0]  d_awlock,
   output logic [3:0]  d_awcache,
   output logic [2:0]  d_awprot,
   output logic        d_awvalid,
   input  logic        d_awready,

   output logic [3:0]  d_wid,
   output logic [31:0] d_wdata,
   output logic [3:0]  d_wstrb,
   output logic        d_wlast,
   output logic        d_wvalid,
   input  logic        d_wready,

   input  logic [3:0]  d_bid,
   input  logic [1:0]  d_bresp,
   input  logic        d_bvalid,
   output logic        d_bready
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ADDR, R_DATA} r_state_t;

   // Write buffer storage and pointers (extra MSB distinguishes full from empty)
   logic [31:0] buf_addr [DEPTH];
   logic [31:0] buf_data [DEPTH];
   logic [3:0]  buf_sel  [DEPTH];
   logic [PW:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0] rd_ptr_q, rd_ptr_d;
   logic        buf_full, buf_empty, push, pop;

   // Write FSM state
   w_state_t w_state_q, w_state_d;
   logic     awvalid_q, awvalid_d;
   logic     wvalid_q, wvalid_d;
   logic     bready_q, bready_d;
   logic     aw_done_q, aw_done_d;
   logic     w_done_q, w_done_d;

   // Read FSM state
   r_state_t    r_state_q, r_state_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic [31:0] araddr_q, araddr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        killed_q, killed_d;

   logic        unused_inputs;

   assign buf_full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign buf_empty  = (wr_ptr_q == rd_ptr_q);
   assign push       = mem_wen & ~buf_full;
   assign mem_wack   = push;
   assign wbuf_empty = buf_empty & (w_state_q == W_IDLE);

   // Response codes are not reported upstream; the top address bits are dropped by the fixed mapping
   assign unused_inputs = ^{d_rresp, d_bresp, mem_addr[31:29]};

   // Store entries into the buffer; storage itself needs no reset
   always_ff @(posedge clk) begin
      if (push) begin
         buf_addr[wr_ptr_q[PW-1:0]] <= {3'b000, mem_addr[28:0]};
         buf_data[wr_ptr_q[PW-1:0]] <= mem_wdata;
         buf_sel[wr_ptr_q[PW-1:0]]  <= mem_wsel;
      end
   end

   // Pointer advance on push and pop
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
   end

   // Write FSM: drain the head entry as one AW/W pair and wait for its B
   always_comb begin
      w_state_d = w_state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      pop       = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            // a push into an empty buffer lands at the head on this edge, so start now
            if (!buf_empty || push) begin
               w_state_d = W_SEND;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
            end
         end
         W_SEND: begin
            if (awvalid_q && d_awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && d_wready) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               w_state_d = W_RESP;
               bready_d  = 1'b1;
            end
         end
         W_RESP: begin
            if (d_bvalid && (d_bid == ID)) begin
               pop       = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               bready_d  = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read FSM: wait for the write buffer to drain, then one AR and one R beat
   always_comb begin
      r_state_d = r_state_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      araddr_d  = araddr_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      killed_d  = killed_q;
      case (r_state_q)
         R_IDLE: begin
            // the request is still held in the cycle of the completion pulse; ignore it then
            if (mem_ren && !flush && !rvalid_q) r_state_d = R_WAIT;
         end
         R_WAIT: begin
            if (flush) begin
               r_state_d = R_IDLE;
            end else if (wbuf_empty && !push) begin
               r_state_d = R_ADDR;
               arvalid_d = 1'b1;
               araddr_d  = {3'b000, mem_addr[28:0]};
            end
         end
         R_ADDR: begin
            if (flush) killed_d = 1'b1;
            if (d_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (flush) killed_d = 1'b1;
            if (d_rvalid && (d_rid == ID) && d_rlast) begin
               rdata_d   = d_rdata;
               rvalid_d  = ~killed_d;
               killed_d  = 1'b0;
               rready_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // State registers; reset drops every AXI valid/ready immediately
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         w_state_q <= W_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         r_state_q <= R_IDLE;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         araddr_q  <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         killed_q  <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         w_state_q <= w_state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         r_state_q <= r_state_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         araddr_q  <= araddr_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         killed_q  <= killed_d;
      end
   end

   assign mem_rdata  = rdata_q;
   assign mem_rvalid = rvalid_q;

   assign d_arid     = ID;
   assign d_araddr   = araddr_q;
   assign d_arlen    = 4'd0;
   assign d_arsize   = 3'b010;
   assign d_arburst  = 2'b01;
   assign d_arlock   = 2'd0;
   assign d_arcache  = 4'd0;
   assign d_arprot   = 3'd0;
   assign d_arvalid  = arvalid_q;
   assign d_rready   = rready_q;

   assign d_awid     = ID;
   assign d_awaddr   = buf_addr[rd_ptr_q[PW-1:0]];
   assign d_awlen    = 4'd0;
   assign d_awsize   = 3'b010;
   assign d_awburst  = 2'b01;
   assign d_awlock   = 2'd0;
   assign d_awcache  = 4'd0;
   assign d_awprot   = 3'd0;
   assign d_awvalid  = awvalid_q;

   assign d_wid      = ID;
   assign d_wdata    = buf_data[rd_ptr_q[PW-1:0]];
   assign d_wstrb    = buf_sel[rd_ptr_q[PW-1:0]];
   assign d_wlast    = 1'b1;
   assign d_wvalid   = wvalid_q;
   assign d_bready   = bready_q;

endmodule

// File: tb/tb_uncached_data_axi.sv
// tb/tb_uncached_data_axi.sv - directed bench for uncached_data_axi
module tb_uncached_data_axi;

   logic        clk = 1'b0;
   logic        resetn, flush, mem_ren, mem_wen;
   logic [3:0]  mem_wsel;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rvalid, mem_wack, wbuf_empty;
   logic [3:0]  d_arid, d_arlen, d_arcache, d_awid, d_awlen, d_awcache, d_wid, d_wstrb;
   logic [31:0] d_araddr, d_awaddr, d_wdata;
   logic [2:0]  d_arsize, d_arprot, d_awsize, d_awprot;
   logic [1:0]  d_arburst, d_arlock, d_awburst, d_awlock;
   logic        d_arvalid, d_arready, d_rready, d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bready;
   logic [3:0]  d_rid, d_bid;
   logic [31:0] d_rdata;
   logic [1:0]  d_rresp, d_bresp;
   logic        d_rlast, d_rvalid, d_bvalid;

   // slave-side controls used by the responder process
   logic        auto_b, b_en, auto_r, man_bvalid, man_rvalid, man_rlast;
   logic [3:0]  man_rid;
   logic [31:0] man_rdata, r_data;

   int checks = 0;
   int errors = 0;

   logic [31:0] aw_q[$];
   logic [35:0] w_q[$];
   logic [31:0] ar_q[$];
   int          arv_cnt = 0;
   int          rv_cnt  = 0;

   uncached_data_axi #(.ID(4'd1), .DEPTH(4)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wsel(mem_wsel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .mem_wack(mem_wack), .wbuf_empty(wbuf_empty),
      .d_arid(d_arid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
      .d_arburst(d_arburst), .d_arlock(d_arlock), .d_arcache(d_arcache), .d_arprot(d_arprot),
      .d_arvalid(d_arvalid), .d_arready(d_arready),
      .d_rid(d_rid), .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rlast(d_rlast),
      .d_rvalid(d_rvalid), .d_rready(d_rready),
      .d_awid(d_awid), .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize),
      .d_awburst(d_awburst), .d_awlock(d_awlock), .d_awcache(d_awcache), .d_awprot(d_awprot),
      .d_awvalid(d_awvalid), .d_awready(d_awready),
      .d_wid(d_wid), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
      .d_wvalid(d_wvalid), .d_wready(d_wready),
      .d_bid(d_bid), .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Responder: owns the B and R input wires, either reactive or copied from manual values
   initial begin
      d_bvalid = 1'b0; d_rvalid = 1'b0; d_rid = 4'd1; d_rlast = 1'b1; d_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         d_bvalid = auto_b ? (b_en & d_bready) : man_bvalid;
         if (auto_r) begin
            d_rvalid = d_rready; d_rid = 4'd1; d_rlast = 1'b1; d_rdata = r_data;
         end else begin
            d_rvalid = man_rvalid; d_rid = man_rid; d_rlast = man_rlast; d_rdata = man_rdata;
         end
      end
   end

   // Handshake recorder; a handshake seen mid-cycle completes at the next rising edge
   always @(negedge clk) begin
      if (d_awvalid && d_awready) aw_q.push_back(d_awaddr);
      if (d_wvalid && d_wready)   w_q.push_back({d_wdata, d_wstrb});
      if (d_arvalid && d_arready) ar_q.push_back(d_araddr);
      if (d_arvalid)  arv_cnt++;
      if (mem_rvalid) rv_cnt++;
   end

   typedef struct {
      logic ren, wen; logic [3:0] wsel; logic [31:0] addr, wdata;
      logic awr, wr, bv, arr, rv; logic [31:0] rdata;
      logic e_wack, e_awv, e_wv, e_brdy, e_arv, e_rrdy, e_rvalid, e_empty; logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl[$];

   localparam logic [31:0] SA = 32'hBFAF_F000;
   localparam logic [31:0] LA = 32'hA000_1000;

   initial begin
      bit got, b_seen, ar_early;
      int aw0, w0, ar0, arv0, rv0;

      resetn = 1'b0; flush = 0; mem_ren = 0; mem_wen = 0; mem_wsel = 0; mem_addr = 0; mem_wdata = 0;
      d_arready = 0; d_awready = 0; d_wready = 0; d_bid = 4'd1; d_rresp = 0; d_bresp = 0;
      auto_b = 0; b_en = 0; auto_r = 0; man_bvalid = 0; man_rvalid = 0; man_rlast = 1;
      man_rid = 4'd1; man_rdata = 0; r_data = 0;

      //            ren wen wsel  addr  wdata          awr wr bv arr rv rdata          | wack awv wv brdy arv rrdy rvld empty rdata
      tbl.push_back('{0, 1, 4'h3, SA, 32'h1234_5678, 0, 0, 0, 0, 0, 32'h0,           1, 0, 0, 0, 0, 0, 0, 1, 32'h0});
      tbl.push_back('{0, 0, 4'h0, 0,  32'h0,         0, 1, 0, 0, 0, 32'h0,           0, 1, 1, 0, 0, 0, 0, 0, 32'h0});
      tbl.push_back('{0, 0, 4'h0, 0,  32'h0,         0, 1, 0, 0, 0, 32'h0,           0, 1, 0, 0, 0, 0, 0, 0, 32'h0});
      tbl.push_back('{0, 0, 4'h0, 0,  32'h0,         0, 1, 0, 0, 0, 32'h0,           0, 1, 0, 0, 0, 0, 0, 0, 32'h0});
      tbl.push_back('{0, 0, 4'h0, 0,  32'h0,         1, 1, 0, 0, 0, 32'h0,           0, 1, 0, 0, 0, 0, 0, 0, 32'h0});
      tbl.push_back('{0, 0, 4'h0, 0,  32'h0,         0, 0, 0, 0, 0, 32'h0,           0, 0, 0, 1, 0, 0, 0, 0, 32'h0});
      tbl.push_back('{0, 0, 4'h0, 0,  32'h0,         0, 0, 1, 0, 0, 32'h0,           0, 0, 0, 1, 0, 0, 0, 0, 32'h0});
      tbl.push_back('{0, 0, 4'h0, 0,  32'h0,         0, 0, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 1, 32'h0});
      tbl.push_back('{1, 0, 4'h0, LA, 32'h0,         0, 0, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 1, 32'h0});
      tbl.push_back('{1, 0, 4'h0, LA, 32'h0,         0, 0, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 1, 32'h0});
      tbl.push_back('{1, 0, 4'h0, LA, 32'h0,         0, 0, 0, 1, 0, 32'h0,           0, 0, 0, 0, 1, 0, 0, 1, 32'h0});
      tbl.push_back('{1, 0, 4'h0, LA, 32'h0,         0, 0, 0, 0, 1, 32'hCAFE_F00D,   0, 0, 0, 0, 0, 1, 0, 1, 32'h0});
      tbl.push_back('{1, 0, 4'h0, LA, 32'h0,         0, 0, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_F00D});
      tbl.push_back('{0, 0, 4'h0, 0,  32'h0,         0, 0, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D});
      tbl.push_back('{0, 0, 4'h0, 0,  32'h0,         0, 0, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D});

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_valids", {d_awvalid, d_wvalid, d_bready, d_arvalid, d_rready, mem_rvalid}, 36'h0);
      chk("rst_rdata", mem_rdata, 36'h0);
      chk("rst_wbuf_empty", wbuf_empty, 36'h1);
      chk("fixed_ar", {d_arlen, d_arsize, d_arburst, d_arlock, d_arcache, d_arprot}, {18'h0, 4'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
      chk("fixed_aw", {d_awlen, d_awsize, d_awburst, d_awlock, d_awcache, d_awprot}, {18'h0, 4'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
      chk("fixed_ids", {d_arid, d_awid, d_wid, d_wlast}, {23'h0, 4'd1, 4'd1, 4'd1, 1'b1});
      #1 resetn = 1'b1;

      // table: single store with delayed AWREADY, then a zero-wait load
      for (int i = 0; i < tbl.size(); i++) begin
         step();
         mem_ren = tbl[i].ren; mem_wen = tbl[i].wen; mem_wsel = tbl[i].wsel;
         mem_addr = tbl[i].addr; mem_wdata = tbl[i].wdata;
         d_awready = tbl[i].awr; d_wready = tbl[i].wr; man_bvalid = tbl[i].bv;
         d_arready = tbl[i].arr; man_rvalid = tbl[i].rv; man_rdata = tbl[i].rdata;
         man_rid = 4'd1; man_rlast = 1'b1;
         @(negedge clk);
         chk($sformatf("r%0d_wack", i),    mem_wack,   tbl[i].e_wack);
         chk($sformatf("r%0d_awvalid", i), d_awvalid,  tbl[i].e_awv);
         chk($sformatf("r%0d_wvalid", i),  d_wvalid,   tbl[i].e_wv);
         chk($sformatf("r%0d_bready", i),  d_bready,   tbl[i].e_brdy);
         chk($sformatf("r%0d_arvalid", i), d_arvalid,  tbl[i].e_arv);
         chk($sformatf("r%0d_rready", i),  d_rready,   tbl[i].e_rrdy);
         chk($sformatf("r%0d_rvalid", i),  mem_rvalid, tbl[i].e_rvalid);
         chk($sformatf("r%0d_wbuf_empty", i), wbuf_empty, tbl[i].e_empty);
         chk($sformatf("r%0d_rdata", i),   mem_rdata,  tbl[i].e_rdata);
      end
      chk("single_aw_count", aw_q.size(), 36'd1);
      chk("single_w_count", w_q.size(), 36'd1);
      if (aw_q.size() > 0) chk("single_awaddr", aw_q[0], 36'h1FAF_F000);
      if (w_q.size() > 0)  chk("single_wdata_strb", w_q[0], {32'h1234_5678, 4'b0011});
      chk("load_ar_count", ar_q.size(), 36'd1);
      if (ar_q.size() > 0) chk("load_araddr", ar_q[0], 36'h0000_1000);

      // DEPTH+1 stores with B held off
      aw0 = aw_q.size(); w0 = w_q.size();
      d_awready = 1; d_wready = 1; d_arready = 1; auto_b = 1; b_en = 0; auto_r = 1;
      for (int k = 0; k < 5; k++) begin
         step();
         mem_wen = 1; mem_wsel = 4'hF; mem_addr = 32'hA000_0100 + 32'(4 * k); mem_wdata = 32'h1000 + 32'(k);
         @(negedge clk);
         chk($sformatf("fill%0d_wack", k), mem_wack, (k < 4) ? 36'h1 : 36'h0);
      end
      repeat (2) begin step(); @(negedge clk); chk("full_hold_wack", mem_wack, 36'h0); end
      step(); b_en = 1;
      @(negedge clk); chk("full_b_cycle_wack", mem_wack, 36'h0);
      step();
      @(negedge clk); chk("after_b_wack", mem_wack, 36'h1);
      step(); mem_wen = 0;
      got = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (wbuf_empty) begin got = 1; break; end
      end
      chk("fill_drain", got, 36'h1);
      chk("fill_aw_count", aw_q.size() - aw0, 36'd5);
      chk("fill_w_count", w_q.size() - w0, 36'd5);
      for (int k = 0; k < 5; k++) begin
         if (aw_q.size() > aw0 + k) chk($sformatf("fill%0d_awaddr", k), aw_q[aw0 + k], 36'h0000_0100 + 36'(4 * k));
         if (w_q.size() > w0 + k)   chk($sformatf("fill%0d_wdata", k), w_q[w0 + k], {32'h1000 + 32'(k), 4'hF});
      end

      // store then load to the same address: AR must wait for the store's B
      step(); b_en = 0; r_data = 32'h55AA_55AA;
      mem_wen = 1; mem_addr = 32'hA000_0200; mem_wdata = 32'h55AA_55AA; mem_wsel = 4'hF;
      @(negedge clk); chk("raw_wack", mem_wack, 36'h1);
      step(); mem_wen = 0; mem_ren = 1;
      ar0 = ar_q.size(); got = 0; b_seen = 0; ar_early = 0;
      for (int c = 0; c < 60; c++) begin
         if (c == 5) b_en = 1;
         @(negedge clk);
         if (d_bvalid && d_bready) b_seen = 1;
         if (d_arvalid && !b_seen) ar_early = 1;
         if (mem_rvalid) begin got = 1; break; end
         step();
      end
      chk("raw_rvalid_seen", got, 36'h1);
      chk("raw_ar_after_b", ar_early, 36'h0);
      chk("raw_rdata", mem_rdata, 36'h55AA_55AA);
      if (ar_q.size() > ar0) chk("raw_araddr", ar_q[ar0], 36'h0000_0200);
      step(); mem_ren = 0;
      @(negedge clk); chk("raw_rvalid_one_cycle", mem_rvalid, 36'h0);

      // foreign R IDs interleaved
      auto_r = 0; man_rvalid = 0;
      step(); mem_ren = 1; mem_addr = 32'h8000_0300;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (d_rready) begin got = 1; break; end
      end
      chk("fid_rready_seen", got, 36'h1);
      step(); man_rvalid = 1; man_rid = 4'd2; man_rdata = 32'h1111_1111; man_rlast = 1;
      @(negedge clk); chk("fid_beat1_rready", d_rready, 36'h1);
      step(); man_rdata = 32'h2222_2222;
      @(negedge clk); chk("fid_beat1_ignored", mem_rvalid, 36'h0);
      step(); man_rid = 4'd1; man_rdata = 32'hDEAD_BEEF;
      @(negedge clk); chk("fid_beat2_ignored", mem_rvalid, 36'h0);
      step(); man_rvalid = 0;
      @(negedge clk);
      chk("fid_rvalid", mem_rvalid, 36'h1);
      chk("fid_rdata", mem_rdata, 36'hDEAD_BEEF);
      step(); mem_ren = 0;

      // flush while waiting for the buffer: no AR at all
      auto_r = 1; b_en = 0; arv0 = arv_cnt; rv0 = rv_cnt;
      step(); mem_wen = 1; mem_addr = 32'hA000_0400; mem_wdata = 32'h4444_4444;
      step(); mem_wen = 0; mem_ren = 1;
      step(); mem_ren = 0; flush = 1;
      @(negedge clk); chk("fwait_arvalid", d_arvalid, 36'h0);
      step(); flush = 0; b_en = 1;
      got = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (wbuf_empty) begin got = 1; break; end
      end
      chk("fwait_drain", got, 36'h1);
      repeat (4) step();
      chk("fwait_no_ar", arv_cnt - arv0, 36'd0);
      chk("fwait_no_rvalid", rv_cnt - rv0, 36'd0);

      // flush during R_DATA: beat accepted, pulse suppressed
      auto_r = 0; man_rvalid = 0; rv0 = rv_cnt;
      step(); mem_ren = 1; mem_addr = 32'hA000_0500;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (d_rready) begin got = 1; break; end
      end
      chk("fdata_rready_seen", got, 36'h1);
      step(); mem_ren = 0; flush = 1;
      @(negedge clk); chk("fdata_rready_held", d_rready, 36'h1);
      step(); flush = 0; man_rvalid = 1; man_rid = 4'd1; man_rlast = 1; man_rdata = 32'h7777_7777;
      @(negedge clk); chk("fdata_beat_accepted", d_rready, 36'h1);
      step(); man_rvalid = 0;
      @(negedge clk);
      chk("fdata_rvalid_killed", mem_rvalid, 36'h0);
      chk("fdata_back_idle", d_rready, 36'h0);
      step(); @(negedge clk);
      chk("fdata_no_rvalid", rv_cnt - rv0, 36'd0);

      // reset asserted during W_SEND
      d_awready = 0; d_wready = 0; b_en = 0;
      step(); mem_wen = 1; mem_addr = 32'hA000_0600; mem_wdata = 32'h6666_6666;
      step(); mem_wen = 0;
      @(negedge clk); chk("rstmid_valids_before", {d_awvalid, d_wvalid}, 36'h3);
      #2 resetn = 1'b0;
      #1;
      chk("rstmid_valids_after", {d_awvalid, d_wvalid}, 36'h0);
      chk("rstmid_wbuf_empty", wbuf_empty, 36'h1);
      @(negedge clk); #1 resetn = 1'b1;
      step(); @(negedge clk);
      chk("rstmid_stays_idle", {d_awvalid, d_wvalid, wbuf_empty}, 36'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
